sdtx_blkseq: RTL and testbench
==============================

# sdtx_blkseq

Block-read sequencer that feeds the SD data transmit path one block at a time. On a start command it fetches words from a word-addressed memory port, presents them on a valid/ready stream with `o_last` on the final word of each block, and inserts a programmable idle gap before every block to emulate the card's read-access latency. It sits between a bench or host-side buffer and the data transmitter's `i_valid/o_ready/i_data/i_last` port, and reports progress, completion and abort.

## Interface
- `AW`, 32, word-address width of the memory port
- `LGBLK`, 9, log2 of the maximum block size in bytes
- `i_clk`  in  1  single clock; all logic on its rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_start`  in  1  start command; accepted only in IDLE
- `i_addr`  in  AW  first word address, sampled with `i_start`
- `i_nblocks`  in  16  number of blocks, sampled with `i_start`
- `i_lgblk`  in  4  log2 block size in bytes, sampled with `i_start`
- `i_gap`  in  8  idle cycles before each block, sampled with `i_start`
- `i_abort`  in  1  stop-transmission request
- `o_busy`  out  1  high from the cycle after an accepted start through DONE
- `o_done`  out  1  one-cycle completion pulse
- `o_aborted`  out  1  one-cycle pulse, coincident with `o_done`, when ending by abort
- `o_blocks_sent`  out  16  blocks fully accepted downstream in the current/last command
- `o_rd_req`  out  1  one-cycle memory read request
- `o_rd_addr`  out  AW  read address, valid with `o_rd_req`
- `i_rd_ack`  in  1  read data valid
- `i_rd_data`  in  32  read data
- `o_valid`  out  1  stream word valid
- `i_ready`  in  1  downstream accepts the word
- `o_data`  out  32  stream word
- `o_last`  out  1  final word of the current block

## Operation
- States: IDLE, GAP, FETCH, WAIT, SEND, DONE.
- IDLE: on `i_start` latch all command inputs, clear `o_blocks_sent`. Go to DONE if `i_nblocks`==0, else GAP (or FETCH if `i_gap`==0). `i_start` outside IDLE is ignored.
- Effective block size is `i_lgblk` clamped to [2, LGBLK]. Words per block = 2^(lgblk-2). Word counter width is LGBLK-1 bits.
- GAP: count `i_gap` cycles, then go to FETCH.
- FETCH: assert `o_rd_req` for exactly one cycle with the current address, then go to WAIT. Address increments by 1 per fetch and wraps modulo 2^AW.
- WAIT: on `i_rd_ack` load `o_data` from `i_rd_data`, set `o_valid`, and go to SEND. Set `o_last` if this is the block's final word. `i_rd_ack` in any other state is ignored.
- SEND: hold `o_valid`, `o_data` and `o_last` stable until `i_ready`. On acceptance:
  - Not the last word: go to FETCH.
  - Last word: increment `o_blocks_sent`. If blocks remain, go to GAP/FETCH; otherwise go to DONE.
- DONE: pulse `o_done` for one cycle, then return to IDLE.
- Only one memory read is outstanding at any time. The block never drops `o_valid` without a handshake.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_aborted`=0, `o_blocks_sent`=0, `o_rd_req`=0, `o_rd_addr`=0, `o_valid`=0, `o_data`=0, `o_last`=0. Internal state returns to IDLE.
- Reset mid-transfer takes effect on the next edge. It drops `o_valid` and produces no `o_done`.
- Start to first `o_rd_req`: `i_gap`+1 cycles.
- `i_rd_ack` to `o_valid`: 1 cycle.
- Handshake to next `o_rd_req`: 1 cycle.
- With a 1-cycle memory and `i_ready` held high, steady state is one word every 3 cycles.
- Last-word handshake of the final block to `o_done`: 2 cycles (DONE state registers the pulse).
- `i_nblocks`==0: `o_done` 2 cycles after `i_start`. No reads, no stream words.
- `o_blocks_sent` updates on the same edge that accepts the last word of a block.
- Simultaneous `i_start` and `i_abort` in IDLE: the start is accepted and the abort is ignored.

## Configuration
- Macro `SDTX_BLKSEQ_ABORT_EN` defined:
  - `i_abort` is honoured whenever `o_busy` is high and is latched.
  - Abort during GAP: go to DONE on the next cycle.
  - Abort during FETCH, WAIT or SEND: finish the current block through its `o_last` handshake, then go to DONE with `o_aborted` pulsed alongside `o_done`.
  - The latched abort clears on return to IDLE.
- Macro not defined:
  - `i_abort` is ignored and `o_aborted` is tied to 0.
  - Commands always run to `i_nblocks`.

## Test plan
- Reset, then `i_start`: `i_addr`=0x100, `i_nblocks`=1, `i_lgblk`=4, `i_gap`=0, 1-cycle memory, `i_ready`=1.
  - 4 reads at 0x100..0x103. `o_last` on the 4th word only. `o_blocks_sent`=1, then one `o_done` pulse.
- `i_nblocks`=3, `i_lgblk`=9, `i_gap`=5:
  - 384 words with `o_last` every 128th word. Exactly 5 idle cycles before each block's first `o_rd_req`. `o_blocks_sent` ends at 3.
- Backpressure with random `i_ready` (about 30% high):
  - `o_data`, `o_last` and `o_valid` stable while stalled. Word sequence unchanged. Variable memory latency of 1–7 cycles gives the same result.
- Corner cases:
  - `i_nblocks`=0: `o_done` 2 cycles after start, zero reads.
  - `i_lgblk`=15 clamps to 128 words/block.
  - `i_addr`=2^AW−1 wraps to 0.
  - `i_start` while busy is ignored.
- With `SDTX_BLKSEQ_ABORT_EN`:
  - Abort mid-block 2 of 4: block 2 completes, `o_blocks_sent`=2, `o_done` and `o_aborted` pulse together.
  - Abort in GAP: done next cycle.
  - Without the macro, the same stimulus sends all 4 blocks.
- Reset asserted while in SEND: `o_valid`=0 and state is IDLE on the next cycle. A new start afterwards runs cleanly from `o_blocks_sent`=0.

Source files
------------

// File: rtl/sdtx_blkseq.sv
// sdtx_blkseq
// Block-read sequencer for the SD data transmit path. A start command
// latches an address, block count, block size and idle gap. For each block
// the sequencer idles for the gap, then fetches words one at a time from a
// word-addressed memory port. Each word is presented on a valid/ready stream,
// and o_last marks the final word of the block.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start               start command (accepted only when idle)
//   i_addr/i_nblocks/
//   i_lgblk/i_gap         command parameters, sampled with i_start
//   i_abort               stop request (optional feature, see below)
//   o_busy                command in progress
//   o_done, o_aborted     completion pulse / completion-by-abort pulse
//   o_blocks_sent         blocks fully accepted downstream
//   o_rd_req, o_rd_addr   one-cycle memory read request and its address
//   i_rd_ack, i_rd_data   memory read response
//   o_valid, i_ready,
//   o_data, o_last        transmit stream
//
// Optional feature: define SDTX_BLKSEQ_ABORT_EN to honour i_abort. An abort
// during the inter-block gap ends the command at once. An abort while a
// block is in flight lets that block finish first. Without the macro,
// i_abort is ignored and o_aborted stays 0.

module sdtx_blkseq #(
  parameter int unsigned AW    = 32,
  parameter int unsigned LGBLK = 9
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_nblocks,
  input  logic [3:0]    i_lgblk,
  input  logic [7:0]    i_gap,
  input  logic          i_abort,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_aborted,
  output logic [15:0]   o_blocks_sent,
  output logic          o_rd_req,
  output logic [AW-1:0] o_rd_addr,
  input  logic          i_rd_ack,
  input  logic [31:0]   i_rd_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [31:0]   o_data,
  output logic          o_last
);

  localparam int unsigned CW  = LGBLK - 1;  // word counter width
  localparam int unsigned NBW = 16;
  localparam int unsigned LGW = 4;
  localparam int unsigned GW  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t          state;
  logic [NBW-1:0]  nblocks_q;
  logic [GW-1:0]   gap_q;
  logic [GW-1:0]   gap_cnt;
  logic [CW-1:0]   words_m1_q;
  logic [CW-1:0]   word_cnt;

  logic [LGW-1:0]  eff_lgblk_c;
  logic [CW-1:0]   words_m1_c;
  logic            last_block_c;
  logic            abort_c;       // abort request seen now or earlier
  logic            abort_seen_c;  // abort already latched

  // Clamp the requested block size to [4 bytes, 2^LGBLK bytes].
  always_comb begin
    eff_lgblk_c = i_lgblk;
    if (i_lgblk < LGW'(2)) begin
      eff_lgblk_c = LGW'(2);
    end else if (i_lgblk > LGW'(LGBLK)) begin
      eff_lgblk_c = LGW'(LGBLK);
    end
    words_m1_c = CW'((32'd1 << (eff_lgblk_c - LGW'(2))) - 32'd1);
  end

  assign last_block_c = ((o_blocks_sent + NBW'(1)) == nblocks_q);

`ifdef SDTX_BLKSEQ_ABORT_EN
  logic abort_q;

  // Abort latch. It is armed only while busy, and it is cleared on the way back to idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      abort_q <= 1'b0;
    end else if (state == S_DONE) begin
      abort_q <= 1'b0;
    end else if (o_busy && i_abort) begin
      abort_q <= 1'b1;
    end
  end

  assign abort_c      = abort_q | (o_busy & i_abort);
  assign abort_seen_c = abort_q;
`else
  logic unused_abort;

  assign unused_abort = i_abort;
  assign abort_c      = 1'b0;
  assign abort_seen_c = 1'b0;
`endif

  // Sequencer: state and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_aborted     <= 1'b0;
      o_blocks_sent <= '0;
      o_rd_req      <= 1'b0;
      o_rd_addr     <= '0;
      o_valid       <= 1'b0;
      o_data        <= '0;
      o_last        <= 1'b0;
      nblocks_q     <= '0;
      gap_q         <= '0;
      gap_cnt       <= '0;
      words_m1_q    <= '0;
      word_cnt      <= '0;
    end else begin
      o_done    <= 1'b0;
      o_aborted <= 1'b0;
      o_rd_req  <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            o_busy        <= 1'b1;
            o_blocks_sent <= '0;
            o_rd_addr     <= i_addr;
            nblocks_q     <= i_nblocks;
            gap_q         <= i_gap;
            words_m1_q    <= words_m1_c;
            word_cnt      <= '0;
            if (i_nblocks == '0) begin
              state <= S_DONE;
            end else if (i_gap == '0) begin
              state    <= S_FETCH;
              o_rd_req <= 1'b1;
            end else begin
              state   <= S_GAP;
              gap_cnt <= i_gap - GW'(1);
            end
          end
        end

        // gap_cnt is loaded with gap-1 so the state lasts exactly gap cycles.
        S_GAP: begin
          if (abort_c) begin
            state <= S_DONE;
          end else if (gap_cnt == '0) begin
            state    <= S_FETCH;
            o_rd_req <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        // o_rd_req was raised on entry. The address moves on once it has been issued.
        S_FETCH: begin
          state     <= S_WAIT;
          o_rd_addr <= o_rd_addr + AW'(1);
        end

        S_WAIT: begin
          if (i_rd_ack) begin
            o_valid <= 1'b1;
            o_data  <= i_rd_data;
            o_last  <= (word_cnt == words_m1_q);
            state   <= S_SEND;
          end
        end

        S_SEND: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            if (!o_last) begin
              word_cnt <= word_cnt + CW'(1);
              state    <= S_FETCH;
              o_rd_req <= 1'b1;
            end else begin
              word_cnt      <= '0;
              o_blocks_sent <= o_blocks_sent + NBW'(1);
              if (abort_c || last_block_c) begin
                state <= S_DONE;
              end else if (gap_q == '0) begin
                state    <= S_FETCH;
                o_rd_req <= 1'b1;
              end else begin
                state   <= S_GAP;
                gap_cnt <= gap_q - GW'(1);
              end
            end
          end
        end

        S_DONE: begin
          o_done    <= 1'b1;
          o_aborted <= abort_seen_c;
          o_busy    <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdtx_blkseq.sv
// Testbench for sdtx_blkseq. Random commands are driven into the design.
// A memory model answers reads with random latency, and a reference
// scoreboard of expected words, reads and completion is built from each
// command. A negedge monitor pops and compares as the design responds.
module tb_sdtx_blkseq;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_addr;
  logic [15:0] i_nblocks;
  logic [3:0]  i_lgblk;
  logic [7:0]  i_gap;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic        o_aborted;
  logic [15:0] o_blocks_sent;
  logic        o_rd_req;
  logic [31:0] o_rd_addr;
  logic        i_rd_ack;
  logic [31:0] i_rd_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_last;

  sdtx_blkseq #(.AW(32), .LGBLK(9)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_addr(i_addr),
    .i_nblocks(i_nblocks), .i_lgblk(i_lgblk), .i_gap(i_gap), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
    .o_blocks_sent(o_blocks_sent), .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
    .i_rd_ack(i_rd_ack), .i_rd_data(i_rd_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_last(o_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] data; logic last; } word_t;
  typedef struct { logic [31:0] addr; logic first; } rd_t;

  word_t exp_words[$];
  rd_t   exp_reads[$];
  word_t wtmp;
  rd_t   rtmp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int anchor_cyc = 0;   // start cycle or last-word handshake of previous block
  int hs_cyc = 0;       // most recent handshake cycle
  int exp_gap = 0;
  int exp_blocks = 0;
  int exp_aborted = 0;
  int mdl_blocks = 0;
  int done_cnt = 0;
  int done_target = 0;
  int ready_pct = 100;
  int lat_max = 1;
  bit stall_q = 0;
  logic [31:0] st_data;
  logic        st_last;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory: answers each request after 1..lat_max cycles.
  initial begin
    int lat;
    logic [31:0] a;
    i_rd_ack  = 1'b0;
    i_rd_data = '0;
    forever begin
      @(posedge i_clk); #1;
      if (o_rd_req && !i_reset) begin
        a   = o_rd_addr;
        lat = int'($urandom_range(lat_max, 1));
        repeat (lat) @(posedge i_clk);
        #1;
        i_rd_ack  = 1'b1;
        i_rd_data = mem_word(a);
        @(posedge i_clk); #1;
        i_rd_ack  = 1'b0;
        i_rd_data = $urandom;
      end
    end
  end

  // Downstream ready with programmable duty.
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      i_ready = (int'($urandom_range(99, 0)) < ready_pct);
    end
  end

  // Monitor / scoreboard.
  always @(negedge i_clk) begin
    if (i_reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", 64'(o_valid), 64'd1);
        check("stall_data", 64'(o_data), 64'(st_data));
        check("stall_last", 64'(o_last), 64'(st_last));
      end
      stall_q = o_valid && !i_ready;
      st_data = o_data;
      st_last = o_last;

      check("blocks_sent", 64'(o_blocks_sent), 64'(mdl_blocks));

      if (o_valid && i_ready) begin
        if (exp_words.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got data 0x%0h, expected no word (cycle %0d)", o_data, cyc);
        end else begin
          wtmp = exp_words.pop_front();
          check("word_data", 64'(o_data), 64'(wtmp.data));
          check("word_last", 64'(o_last), 64'(wtmp.last));
        end
        hs_cyc = cyc;
        if (o_last) begin
          anchor_cyc = cyc;
          mdl_blocks++;
        end
      end

      if (o_rd_req) begin
        if (exp_reads.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got addr 0x%0h, expected no read (cycle %0d)", o_rd_addr, cyc);
        end else begin
          rtmp = exp_reads.pop_front();
          check("rd_addr", 64'(o_rd_addr), 64'(rtmp.addr));
          check("rd_timing", 64'(cyc), rtmp.first ? 64'(anchor_cyc + exp_gap + 1) : 64'(hs_cyc + 1));
        end
      end

      if (o_done) begin
        done_cnt++;
        check("done_timing", 64'(cyc), 64'(anchor_cyc + 2));
        check("done_aborted", 64'(o_aborted), 64'(exp_aborted));
        check("done_blocks", 64'(o_blocks_sent), 64'(exp_blocks));
        check("done_left", 64'(exp_words.size() + exp_reads.size()), 64'd0);
      end else begin
        check("aborted_alone", 64'(o_aborted), 64'd0);
      end
    end
  end

  // Builds the expected response of one command and drives the start.
  task automatic issue(input logic [31:0] addr, input int nb, input int lg, input int gap,
                       input int nb_run, input int aborted);
    int eff;
    int words;
    logic [31:0] a;
    eff   = (lg < 2) ? 2 : ((lg > 9) ? 9 : lg);
    words = 1 << (eff - 2);
    for (int b = 0; b < nb_run; b++) begin
      for (int w = 0; w < words; w++) begin
        a = addr + 32'(b * words + w);
        exp_words.push_back('{data: mem_word(a), last: (w == words - 1)});
        exp_reads.push_back('{addr: a, first: (w == 0)});
      end
    end
    exp_blocks  = nb_run;
    exp_aborted = aborted;
    exp_gap     = gap;
    i_start     = 1'b1;
    i_addr      = addr;
    i_nblocks   = 16'(nb);
    i_lgblk     = 4'(lg);
    i_gap       = 8'(gap);
    anchor_cyc  = cyc;
    @(posedge i_clk); #1;
    i_start     = 1'b0;
    mdl_blocks  = 0;
    done_target++;
    check("busy_after_start", 64'(o_busy), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt < done_target && n < 20000) begin
      @(posedge i_clk); #1;
      n++;
    end
    check({name, "_done_seen"}, 64'(done_cnt), 64'(done_target));
    repeat (4) begin
      @(posedge i_clk); #1;
    end
    check({name, "_done_once"}, 64'(done_cnt), 64'(done_target));
    check({name, "_idle"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] ra;
    i_reset = 1'b1; i_start = 1'b0; i_addr = '0; i_nblocks = '0;
    i_lgblk = '0; i_gap = '0; i_abort = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_aborted", 64'(o_aborted), 64'd0);
    check("rst_blocks", 64'(o_blocks_sent), 64'd0);
    check("rst_rd_req", 64'(o_rd_req), 64'd0);
    check("rst_rd_addr", 64'(o_rd_addr), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_last", 64'(o_last), 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // Basic single block.
    ready_pct = 100; lat_max = 1;
    issue(32'h100, 1, 4, 0, 1, 0);
    wait_done("basic");

    // Three full-size blocks with a gap of 5.
    issue($urandom, 3, 9, 5, 3, 0);
    wait_done("big");

    // Backpressure, fixed then variable memory latency, same command.
    ra = $urandom;
    ready_pct = 30; lat_max = 1;
    issue(ra, 2, 5, 1, 2, 0);
    wait_done("bp_lat1");
    lat_max = 7;
    issue(ra, 2, 5, 1, 2, 0);
    wait_done("bp_lat7");

    // Random commands.
    for (int i = 0; i < 6; i++) begin
      int nb;
      int lg;
      int gp;
      ready_pct = int'($urandom_range(100, 30));
      lat_max   = int'($urandom_range(7, 1));
      nb = int'($urandom_range(3, 1));
      lg = int'($urandom_range(7, 0));
      gp = int'($urandom_range(4, 0));
      issue($urandom, nb, lg, gp, nb, 0);
      wait_done("random");
    end

    // Corner cases.
    ready_pct = 100; lat_max = 1;
    issue(32'h40, 0, 4, 3, 0, 0);
    wait_done("zero_blocks");
    issue(32'h8000, 1, 15, 0, 1, 0);
    wait_done("clamp_hi");
    issue(32'h200, 2, 0, 1, 2, 0);
    wait_done("clamp_lo");
    issue(32'hFFFF_FFFF, 1, 4, 2, 1, 0);
    wait_done("addr_wrap");

    // Start while busy is ignored.
    issue(32'h300, 2, 3, 3, 2, 0);
    repeat (5) begin
      @(posedge i_clk); #1;
    end
    check("busy_mid_cmd", 64'(o_busy), 64'd1);
    i_start = 1'b1; i_addr = 32'hDEAD_0000; i_nblocks = 16'd7; i_lgblk = 4'd9; i_gap = 8'd0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done("busy_start");

    // Abort while block 2 of 4 is in flight.
`ifdef SDTX_BLKSEQ_ABORT_EN
    issue(32'h500, 4, 4, 2, 2, 1);
`else
    issue(32'h500, 4, 4, 2, 4, 0);
`endif
    n = 0;
    while (o_blocks_sent != 16'd1 && n < 1000) begin
      @(posedge i_clk); #1; n++;
    end
    n = 0;
    while (!o_valid && n < 1000) begin
      @(posedge i_clk); #1; n++;
    end
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    wait_done("abort_mid");

    // Abort during the leading gap.
`ifdef SDTX_BLKSEQ_ABORT_EN
    issue(32'h600, 3, 2, 20, 0, 1);
`else
    issue(32'h600, 3, 2, 20, 3, 0);
`endif
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    i_abort = 1'b1;
`ifdef SDTX_BLKSEQ_ABORT_EN
    anchor_cyc = cyc;
`endif
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    wait_done("abort_gap");

    // Reset while a word is stalled in SEND, then a clean restart.
    ready_pct = 0;
    issue(32'h2000, 2, 4, 0, 2, 0);
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge i_clk); #1; n++;
    end
    check("rst_in_send", 64'(o_valid), 64'd1);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    exp_words.delete();
    exp_reads.delete();
    mdl_blocks = 0;
    done_target--;
    @(negedge i_clk);
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_blocks", 64'(o_blocks_sent), 64'd0);
    check("midrst_done", 64'(o_done), 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    ready_pct = 100;
    @(posedge i_clk); #1;
    issue(32'h3000, 2, 3, 1, 2, 0);
    wait_done("after_rst");
    check("done_count_total", 64'(done_cnt), 64'(done_target));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
